mips_mc_main_ctrl: RTL and testbench
====================================

# mips_mc_main_ctrl

Main control FSM for the multi-cycle MIPS datapath. Sequences one instruction at a time through fetch, decode, execute, memory and write-back steps. Drives every datapath select and enable, including the 5-bit write-register mux select (`reg_dst`: 0 selects rt, 1 selects rd). Stalls on a memory ready handshake.

## Interface
Parameters: none; opcodes are fixed constants (R-type 6'b000000, lw 6'b100011, sw 6'b101011, beq 6'b000100, addi 6'b001000, j 6'b000010).
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset; one clock domain
- `op`  in  6  instruction opcode from the instruction register
- `mem_ready`  in  1  memory has completed the current read/write this cycle
- `pc_write`  out  1  unconditional PC load
- `pc_write_cond`  out  1  PC load if ALU zero (branch)
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALU out
- `mem_read`  out  1  memory read request
- `mem_write`  out  1  memory write request
- `ir_write`  out  1  instruction register load
- `mem_to_reg`  out  1  write-back data select: 0 = ALU out, 1 = memory data
- `reg_dst`  out  1  write-register mux select: 0 = rt, 1 = rd
- `reg_write`  out  1  register file write enable
- `alu_src_a`  out  1  0 = PC, 1 = register A
- `alu_src_b`  out  2  00 = B, 01 = constant 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- `alu_op`  out  2  00 = add, 01 = subtract, 10 = funct-decoded
- `pc_src`  out  2  00 = ALU result, 01 = ALU out reg, 10 = jump target
- `illegal_op`  out  1  sticky flag: an unsupported opcode was decoded
- `state`  out  4  current state (debug)

## Operation
- Moore FSM with a 4-bit state register.
- Every output is a combinational decode of `state`, except two:
  - `ir_write` and `pc_write` in FETCH are also gated by `mem_ready`.
  - `illegal_op` is a register.
- Any output not listed for a state is 0.
- State encodings and per-state outputs:
  - IDLE=0: all outputs 0. Next state: FETCH.
  - FETCH=1: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write = pc_write = mem_ready. Next: DECODE if mem_ready, else stay.
  - DECODE=2: alu_src_a=0, alu_src_b=11, alu_op=00. Next by `op`:
    - lw/sw go to MEMADR.
    - R-type goes to RTYPEEX.
    - beq goes to BEQEX.
    - addi goes to ADDIEX.
    - j goes to JEX.
    - Any other opcode goes to FETCH and sets `illegal_op`.
  - MEMADR=3: alu_src_a=1, alu_src_b=10, alu_op=00. Next: MEMRD if op=lw, else MEMWR.
  - MEMRD=4: mem_read=1, i_or_d=1. Next: MEMWB if mem_ready, else stay.
  - MEMWB=5: reg_dst=0, mem_to_reg=1, reg_write=1. Next: FETCH.
  - MEMWR=6: mem_write=1, i_or_d=1. Next: FETCH if mem_ready, else stay.
  - RTYPEEX=7: alu_src_a=1, alu_src_b=00, alu_op=10. Next: RTYPEWB.
  - RTYPEWB=8: reg_dst=1, mem_to_reg=0, reg_write=1. Next: FETCH.
  - BEQEX=9: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01. Next: FETCH.
  - ADDIEX=10: alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDIWB.
  - ADDIWB=11: reg_dst=0, mem_to_reg=0, reg_write=1. Next: FETCH.
  - JEX=12: pc_write=1, pc_src=10. Next: FETCH.
  - Encodings 13-15: all outputs 0. Next: IDLE.
- `mem_ready` is sampled only in FETCH, MEMRD and MEMWR; it is ignored in every other state.
- `op` is sampled only in DECODE and MEMADR.

## Timing
- Reset (asynchronous): `state` = IDLE immediately, so all outputs read 0 in the same cycle. `illegal_op` is cleared. This holds mid-instruction too: any in-flight write enable drops immediately.
- First FETCH occurs one clock after `rst_n` deasserts.
- Minimum cycles per instruction, counted from FETCH entry with `mem_ready` held high:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
- Each cycle `mem_ready` is low in FETCH, MEMRD or MEMWR adds one cycle; outputs hold steady during the wait.
- `illegal_op` rises on the clock edge that leaves DECODE with an unsupported opcode. It stays high until reset.
- `reg_write` and `mem_write` are each high for exactly one cycle per instruction when `mem_ready` is high on its first sample.

## Configuration
- `MIPS_MC_CTRL_JUMP_EN` defined: opcode 6'b000010 is decoded and goes to JEX.
- Undefined: JEX is not compiled in. Opcode 6'b000010 is treated as illegal (DECODE goes to FETCH, `illegal_op` set), and `pc_src` never equals 10.
- Encoding 12 then behaves as an unused encoding (next state IDLE).

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release -> state=0 with all outputs 0 while in reset; state=1 with mem_read=1 one clock after release.
- lw with mem_ready=1 throughout -> states 1,2,3,4,5,1. In state 5: reg_write=1, reg_dst=0, mem_to_reg=1. Total 5 cycles.
- R-type with mem_ready low for 2 cycles in FETCH -> FETCH lasts 3 cycles; ir_write=1 only in the third; RTYPEWB has reg_dst=1 and reg_write=1.
- sw with mem_ready low for 1 cycle in MEMWR -> mem_write=1 for 2 cycles and reg_write never 1; then FETCH.
- op=6'b111111 -> DECODE goes to FETCH and illegal_op=1 stays set. Repeat with op=6'b000010 with the macro undefined -> illegal_op=1; with it defined -> JEX has pc_write=1, pc_src=10.
- Async reset asserted during RTYPEWB -> reg_write drops to 0 before the next clock edge, and state=0.

Source files
------------

// File: rtl/mips_mc_main_ctrl.sv
// Multi-cycle MIPS main control FSM: fetch/decode/execute/memory/write-back sequencing.
// Optional jump support: define MIPS_MC_CTRL_JUMP_EN to decode opcode 6'b000010 into JEX.
module mips_mc_main_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MIPS_MC_CTRL_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    MEMADR  = 4'd3,
    MEMRD   = 4'd4,
    MEMWB   = 4'd5,
    MEMWR   = 4'd6,
    RTYPEEX = 4'd7,
    RTYPEWB = 4'd8,
    BEQEX   = 4'd9,
    ADDIEX  = 4'd10,
`ifdef MIPS_MC_CTRL_JUMP_EN
    ADDIWB  = 4'd11,
    JEX     = 4'd12
`else
    ADDIWB  = 4'd11
`endif
  } state_e;

  state_e r_state;
  state_e w_next;
  logic   r_illegal;
  logic   w_bad_op;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Sticky illegal-opcode flag, set when DECODE rejects the opcode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_illegal <= 1'b0;
    else if (w_bad_op) r_illegal <= 1'b1;
  end

  // Next-state and Moore output decode
  always_comb begin
    w_next        = r_state;
    w_bad_op      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_src        = 2'b00;
    case (r_state)
      IDLE: w_next = FETCH;
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) w_next = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYPE:     w_next = RTYPEEX;
          OP_BEQ:       w_next = BEQEX;
          OP_ADDI:      w_next = ADDIEX;
`ifdef MIPS_MC_CTRL_JUMP_EN
          OP_J:         w_next = JEX;
`endif
          default: begin
            w_next   = FETCH;
            w_bad_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) w_next = MEMWB;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        w_next     = FETCH;
      end
      MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) w_next = FETCH;
      end
      RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        w_next    = RTYPEWB;
      end
      RTYPEWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        w_next    = FETCH;
      end
      BEQEX: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        w_next        = FETCH;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        w_next    = FETCH;
      end
`ifdef MIPS_MC_CTRL_JUMP_EN
      JEX: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        w_next   = FETCH;
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  assign illegal_op = r_illegal;
  assign state      = r_state;

endmodule

// File: tb/tb_mips_mc_main_ctrl.sv
// Directed bench for mips_mc_main_ctrl: walks each instruction class with hand-computed outputs.
module tb_mips_mc_main_ctrl;

  logic       clk;
  logic       rst_n;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // Output bus order: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
  // mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_src[1:0]
  localparam logic [15:0] O_IDLE    = 16'h0000;
  localparam logic [15:0] O_FETCH   = 16'h9410;
  localparam logic [15:0] O_FWAIT   = 16'h1010;
  localparam logic [15:0] O_DECODE  = 16'h0030;
  localparam logic [15:0] O_MEMADR  = 16'h0060;
  localparam logic [15:0] O_MEMRD   = 16'h3000;
  localparam logic [15:0] O_MEMWB   = 16'h0280;
  localparam logic [15:0] O_MEMWR   = 16'h2800;
  localparam logic [15:0] O_RTYPEEX = 16'h0048;
  localparam logic [15:0] O_RTYPEWB = 16'h0180;
  localparam logic [15:0] O_BEQEX   = 16'h4045;
  localparam logic [15:0] O_ADDIEX  = 16'h0060;
  localparam logic [15:0] O_ADDIWB  = 16'h0080;
  localparam logic [15:0] O_JEX     = 16'h8002;

  logic [15:0] w_outs;
  assign w_outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src};

  mips_mc_main_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .illegal_op(illegal_op), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One cycle: drive inputs at negedge, then check state/outputs/flag mid-cycle
  task automatic cyc(input logic [5:0] i_op, input logic i_mr, input logic [3:0] exp_st,
                     input logic [15:0] exp_o, input logic exp_ill);
    @(negedge clk);
    op        = i_op;
    mem_ready = i_mr;
    #1;
    check("state", 32'(state), 32'(exp_st));
    check("outs", 32'(w_outs), 32'(exp_o));
    check("illegal", 32'(illegal_op), 32'(exp_ill));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_outs", 32'(w_outs), 32'(O_IDLE));
    check("rst_ill", 32'(illegal_op), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_state", 32'(state), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b1;
    op        = OP_R;
    mem_ready = 1'b0;
    #1 rst_n  = 1'b0;
    // Reset held for three cycles with mem_ready high: outputs stay 0
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      check("rst_state", 32'(state), 32'd0);
      check("rst_outs", 32'(w_outs), 32'(O_IDLE));
      check("rst_ill", 32'(illegal_op), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_state", 32'(state), 32'd0);

    // lw at full speed: 1,2,3,4,5
    cyc(OP_LW, 1'b1, 4'd1, O_FETCH,  1'b0);
    cyc(OP_LW, 1'b1, 4'd2, O_DECODE, 1'b0);
    cyc(OP_LW, 1'b0, 4'd3, O_MEMADR, 1'b0);
    cyc(OP_LW, 1'b1, 4'd4, O_MEMRD,  1'b0);
    cyc(OP_LW, 1'b1, 4'd5, O_MEMWB,  1'b0);

    // R-type with FETCH stalled two cycles
    cyc(OP_R, 1'b0, 4'd1, O_FWAIT,   1'b0);
    cyc(OP_R, 1'b0, 4'd1, O_FWAIT,   1'b0);
    cyc(OP_R, 1'b1, 4'd1, O_FETCH,   1'b0);
    cyc(OP_R, 1'b1, 4'd2, O_DECODE,  1'b0);
    cyc(OP_R, 1'b0, 4'd7, O_RTYPEEX, 1'b0);
    cyc(OP_R, 1'b1, 4'd8, O_RTYPEWB, 1'b0);

    // sw with MEMWR stalled one cycle
    cyc(OP_SW, 1'b1, 4'd1, O_FETCH,  1'b0);
    cyc(OP_SW, 1'b1, 4'd2, O_DECODE, 1'b0);
    cyc(OP_SW, 1'b1, 4'd3, O_MEMADR, 1'b0);
    cyc(OP_SW, 1'b0, 4'd6, O_MEMWR,  1'b0);
    cyc(OP_SW, 1'b1, 4'd6, O_MEMWR,  1'b0);

    // beq, with mem_ready low in DECODE (ignored there)
    cyc(OP_BEQ, 1'b1, 4'd1, O_FETCH,  1'b0);
    cyc(OP_BEQ, 1'b0, 4'd2, O_DECODE, 1'b0);
    cyc(OP_BEQ, 1'b0, 4'd9, O_BEQEX,  1'b0);

    // addi
    cyc(OP_ADDI, 1'b1, 4'd1,  O_FETCH,  1'b0);
    cyc(OP_ADDI, 1'b1, 4'd2,  O_DECODE, 1'b0);
    cyc(OP_ADDI, 1'b1, 4'd10, O_ADDIEX, 1'b0);
    cyc(OP_ADDI, 1'b1, 4'd11, O_ADDIWB, 1'b0);

    // lw with MEMRD stalled one cycle
    cyc(OP_LW, 1'b1, 4'd1, O_FETCH,  1'b0);
    cyc(OP_LW, 1'b1, 4'd2, O_DECODE, 1'b0);
    cyc(OP_LW, 1'b1, 4'd3, O_MEMADR, 1'b0);
    cyc(OP_LW, 1'b0, 4'd4, O_MEMRD,  1'b0);
    cyc(OP_LW, 1'b1, 4'd4, O_MEMRD,  1'b0);
    cyc(OP_LW, 1'b1, 4'd5, O_MEMWB,  1'b0);

    // Unsupported opcode: back to FETCH, flag sticks across the next instruction
    cyc(OP_BAD, 1'b1, 4'd1, O_FETCH,   1'b0);
    cyc(OP_BAD, 1'b1, 4'd2, O_DECODE,  1'b0);
    cyc(OP_R,   1'b1, 4'd1, O_FETCH,   1'b1);
    cyc(OP_R,   1'b1, 4'd2, O_DECODE,  1'b1);
    cyc(OP_R,   1'b1, 4'd7, O_RTYPEEX, 1'b1);

    // Jump opcode after a fresh reset
    do_reset();
    cyc(OP_J, 1'b1, 4'd1, O_FETCH,  1'b0);
    cyc(OP_J, 1'b1, 4'd2, O_DECODE, 1'b0);
`ifdef MIPS_MC_CTRL_JUMP_EN
    cyc(OP_J, 1'b1, 4'd12, O_JEX,   1'b0);
    cyc(OP_J, 1'b1, 4'd1,  O_FETCH, 1'b0);
`else
    cyc(OP_J, 1'b1, 4'd1,  O_FETCH, 1'b1);
`endif

    // Async reset in RTYPEWB drops reg_write before the next edge
    do_reset();
    cyc(OP_R, 1'b1, 4'd1, O_FETCH,   1'b0);
    cyc(OP_R, 1'b1, 4'd2, O_DECODE,  1'b0);
    cyc(OP_R, 1'b1, 4'd7, O_RTYPEEX, 1'b0);
    cyc(OP_R, 1'b1, 4'd8, O_RTYPEWB, 1'b0);
    check("wb_rw", 32'(reg_write), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_rw", 32'(reg_write), 32'd0);
    check("arst_state", 32'(state), 32'd0);
    check("arst_outs", 32'(w_outs), 32'(O_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    cyc(OP_R, 1'b1, 4'd1, O_FETCH, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
